// File: rtl/cray_vec_pkg.sv
// Shared types and default sizing for the vector add/sub datapath.
package cray_vec_pkg;

  localparam int unsigned ELEM_W_DEF   = 8;
  localparam int unsigned LANES_DEF    = 4;
  localparam int unsigned VLEN_MAX_DEF = 64;

  typedef enum logic [1:0] {
    VOP_ADD  = 2'b00,
    VOP_SUB  = 2'b01,
    VOP_RSUB = 2'b10,
    VOP_MAXU = 2'b11
  } vop_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// One combinational unsigned add/sub/max lane with carry/borrow flag.
// Optional saturation when VADD_SAT_EN is defined.
module vec_lane_alu
  import cray_vec_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF
) (
  input  logic [ELEM_W-1:0] a_i,
  input  logic [ELEM_W-1:0] b_i,
  input  logic [1:0]        op_i,
  output logic [ELEM_W-1:0] res_o,
  output logic              flag_o
);

  logic [ELEM_W:0] ext;

  always_comb begin
    ext = '0;
    case (vop_e'(op_i))
      VOP_ADD:  ext = {1'b0, a_i} + {1'b0, b_i};
      VOP_SUB:  ext = {1'b0, a_i} - {1'b0, b_i};
      VOP_RSUB: ext = {1'b0, b_i} - {1'b0, a_i};
      VOP_MAXU: ext = {1'b0, (a_i > b_i) ? a_i : b_i};
      default:  ext = '0;
    endcase
    flag_o = ext[ELEM_W];
    res_o  = ext[ELEM_W-1:0];
`ifdef VADD_SAT_EN
    // MAXU never sets the top bit, so only add/sub reach the clamp.
    if (flag_o) res_o = (vop_e'(op_i) == VOP_ADD) ? '1 : '0;
`endif
  end

endmodule

// File: rtl/vec_addsub_stream.sv
// Streaming vector add/sub unit: command, VL-length beat stream, 2-stage pipeline.
// Saturating arithmetic is selected by defining VADD_SAT_EN.
module vec_addsub_stream
  import cray_vec_pkg::*;
#(
  parameter int unsigned ELEM_W   = ELEM_W_DEF,
  parameter int unsigned LANES    = LANES_DEF,
  parameter int unsigned VLEN_MAX = VLEN_MAX_DEF,
  parameter int unsigned VL_W     = $clog2(VLEN_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [VL_W-1:0]         cmd_vl,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*ELEM_W-1:0] in_a,
  input  logic [LANES*ELEM_W-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ELEM_W-1:0] out_data,
  output logic [LANES-1:0]        out_mask,
  output logic [LANES-1:0]        out_flag,
  output logic                    out_last
);

  localparam logic [VL_W-1:0] LanesVl = VL_W'(LANES);

  state_e                  state_q, state_d;
  vop_e                    op_q, op_d;
  logic [VL_W-1:0]         rem_q, rem_d;
  logic                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [LANES*ELEM_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [LANES-1:0]        s1_mask_q, s1_mask_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [LANES*ELEM_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]        out_mask_q, out_mask_d, out_flag_q, out_flag_d;

  logic                    adv, beat_acc, beat_last;
  logic [LANES-1:0]        beat_mask, lane_flag;
  logic [LANES*ELEM_W-1:0] a_masked, b_masked, lane_res;

  assign adv       = !out_valid_q | out_ready;
  assign in_ready  = (state_q == ST_RUN) & adv;
  assign beat_acc  = in_valid & in_ready;
  assign beat_last = (rem_q <= LanesVl);

  // Masked lanes carry zero operands, which yields zero result and flag for every op.
  always_comb begin
    beat_mask = '0;
    a_masked  = '0;
    b_masked  = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_mask[i] = (i < int'(rem_q));
      if (beat_mask[i]) begin
        a_masked[i*ELEM_W +: ELEM_W] = in_a[i*ELEM_W +: ELEM_W];
        b_masked[i*ELEM_W +: ELEM_W] = in_b[i*ELEM_W +: ELEM_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    cmd_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d  = vop_e'(cmd_op);
          rem_d = cmd_vl;
          if (cmd_vl != '0) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (beat_acc) begin
          rem_d = beat_last ? '0 : rem_q - LanesVl;
          if (beat_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready && out_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vec_lane_alu #(
      .ELEM_W(ELEM_W)
    ) u_lane (
      .a_i   (s1_a_q[g*ELEM_W +: ELEM_W]),
      .b_i   (s1_b_q[g*ELEM_W +: ELEM_W]),
      .op_i  (op_q),
      .res_o (lane_res[g*ELEM_W +: ELEM_W]),
      .flag_o(lane_flag[g])
    );
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_mask_d   = s1_mask_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_flag_d  = out_flag_q;
    out_last_d  = out_last_q;
    if (adv) begin
      s1_valid_d  = beat_acc;
      out_valid_d = s1_valid_q;
      if (beat_acc) begin
        s1_a_d    = a_masked;
        s1_b_d    = b_masked;
        s1_mask_d = beat_mask;
        s1_last_d = beat_last;
      end
      if (s1_valid_q) begin
        out_data_d = lane_res;
        out_flag_d = lane_flag;
        out_mask_d = s1_mask_q;
        out_last_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= VOP_ADD;
      rem_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mask_q   <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_flag_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mask_q   <= s1_mask_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_flag_q  <= out_flag_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign out_flag  = out_flag_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_vec_addsub_stream.sv
// Self-checking bench for vec_addsub_stream: vector table plus scoreboarded streams.
module tb_vec_addsub_stream;

  localparam int LN   = 4;
  localparam int EW   = 8;
  localparam int DW   = LN * EW;
  localparam int VL_W = 7;

  logic            clk, rst_n;
  logic            cmd_valid, cmd_ready;
  logic [1:0]      cmd_op;
  logic [VL_W-1:0] cmd_vl;
  logic            in_valid, in_ready;
  logic [DW-1:0]   in_a, in_b;
  logic            out_valid, out_ready;
  logic [DW-1:0]   out_data;
  logic [LN-1:0]   out_mask, out_flag;
  logic            out_last;

  vec_addsub_stream #(
    .ELEM_W  (EW),
    .LANES   (LN),
    .VLEN_MAX(64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_vl   (cmd_vl),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mask (out_mask),
    .out_flag (out_flag),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [LN-1:0] mask;
    logic [LN-1:0] flag;
    logic          last;
  } beat_t;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] d;
    logic [LN-1:0] f;
  } tv_t;

  beat_t      sb_q[$];
  tv_t        tbl[6];
  logic [7:0] va[64];
  logic [7:0] vb[64];
  int         checks = 0, failures = 0, popped = 0, lasts = 0;
  logic       rnd_rdy = 1'b0;
  logic       stalled = 1'b0;
  beat_t      held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference lane: {flag, result}
  function automatic logic [8:0] lane_model(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    int         r;
    logic       f;
    logic [7:0] v;
    f = 1'b0;
    v = 8'h00;
    case (op)
      2'd0: begin
        r = int'(a) + int'(b);
        f = (r > 255);
        v = 8'(r);
`ifdef VADD_SAT_EN
        if (f) v = 8'hFF;
`endif
      end
      2'd1, 2'd2: begin
        r = (op == 2'd1) ? int'(a) - int'(b) : int'(b) - int'(a);
        f = (r < 0);
        v = 8'(r);
`ifdef VADD_SAT_EN
        if (f) v = 8'h00;
`endif
      end
      default: v = (a > b) ? a : b;
    endcase
    return {f, v};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("stall_hold", {out_valid, out_last, out_flag, out_mask, out_data},
              {1'b1, held.last, held.flag, held.mask, held.data});
      if (out_valid && out_ready) begin
        stalled = 1'b0;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0h expected no beat", out_data);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          check("beat", {out_last, out_flag, out_mask, out_data},
                {e.last, e.flag, e.mask, e.data});
          popped++;
          if (out_last) lasts++;
        end
      end else if (out_valid) begin
        stalled   = 1'b1;
        held.data = out_data;
        held.mask = out_mask;
        held.flag = out_flag;
        held.last = out_last;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [VL_W-1:0] vl);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_vl    = vl;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        tick();
        cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    cmd_valid = 1'b0;
    fail_now("cmd_accept");
  endtask

  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input beat_t e);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    fail_now("beat_accept");
  endtask

  // Streams beats of va/vb; n limits how many beats go out (0 = all).
  task automatic send_beats(input logic [1:0] op, input int vl, input int n, input bit gaps);
    int total, lim;
    total = (vl + LN - 1) / LN;
    lim   = (n == 0) ? total : n;
    for (int bt = 0; bt < lim; bt++) begin
      logic [DW-1:0] a, b;
      beat_t         e;
      e.data = '0;
      e.mask = '0;
      e.flag = '0;
      e.last = (bt == total - 1);
      for (int l = 0; l < LN; l++) begin
        int idx;
        idx = bt * LN + l;
        if (idx < vl) begin
          logic [8:0] r;
          a[l*EW +: EW] = va[idx];
          b[l*EW +: EW] = vb[idx];
          r = lane_model(op, va[idx], vb[idx]);
          e.data[l*EW +: EW] = r[7:0];
          e.flag[l] = r[8];
          e.mask[l] = 1'b1;
        end else begin
          a[l*EW +: EW] = 8'($urandom);
          b[l*EW +: EW] = 8'($urandom);
        end
      end
      send_beat(a, b, e);
      if (gaps && $urandom_range(0, 3) == 0) tick();
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        @(negedge clk);
        check("idle_after_drain", {cmd_ready, out_valid, in_ready}, {1'b1, 1'b0, 1'b0});
        tick();
        return;
      end
    end
    fail_now("drain");
    tick();
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
    end
  endtask

  initial begin
    int p0, l0;
    tbl[0] = '{2'd0, 32'h04030201, 32'h281E140A, 32'h2C21160B, 4'b0000};
`ifdef VADD_SAT_EN
    tbl[1] = '{2'd0, 32'h000000F0, 32'h00000020, 32'h000000FF, 4'b0001};
    tbl[2] = '{2'd1, 32'h00000005, 32'h00000007, 32'h00000000, 4'b0001};
    tbl[3] = '{2'd2, 32'h00000903, 32'h00000309, 32'h00000006, 4'b0010};
    tbl[5] = '{2'd0, 32'hFF000000, 32'h01000000, 32'hFF000000, 4'b1000};
`else
    tbl[1] = '{2'd0, 32'h000000F0, 32'h00000020, 32'h00000010, 4'b0001};
    tbl[2] = '{2'd1, 32'h00000005, 32'h00000007, 32'h000000FE, 4'b0001};
    tbl[3] = '{2'd2, 32'h00000903, 32'h00000309, 32'h0000FA06, 4'b0010};
    tbl[5] = '{2'd0, 32'hFF000000, 32'h01000000, 32'h00000000, 4'b1000};
`endif
    tbl[4] = '{2'd3, 32'h0007C803, 32'hFF076409, 32'hFF07C809, 4'b0000};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_vl    = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    #2;
    check("reset_outputs",
          {cmd_ready, in_ready, out_valid, out_last, out_flag, out_mask, out_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0});
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single-beat vectors from the table; first one also checks latency.
    for (int i = 0; i < 6; i++) begin
      beat_t e;
      e.data = tbl[i].d;
      e.mask = 4'b1111;
      e.flag = tbl[i].f;
      e.last = 1'b1;
      send_cmd(tbl[i].op, 7'd4);
      send_beat(tbl[i].a, tbl[i].b, e);
      if (i == 0) begin
        @(negedge clk);
        check("latency_cycle1", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        check("latency_cycle2", {31'h0, out_valid}, 32'h1);
      end
      wait_drain();
    end

    // SUB VL=6: partial second beat.
    fill_random();
    va[0] = 8'd5;
    vb[0] = 8'd7;
    send_cmd(2'd1, 7'd6);
    send_beats(2'd1, 6, 0, 1'b0);
    wait_drain();

    // VL=64 with random backpressure and input gaps.
    fill_random();
    p0 = popped;
    l0 = lasts;
    rnd_rdy = 1'b1;
    send_cmd(2'd0, 7'd64);
    send_beats(2'd0, 64, 0, 1'b1);
    wait_drain();
    check("vl64_beats", 64'(popped - p0), 64'd16);
    check("vl64_lasts", 64'(lasts - l0), 64'd1);
    fill_random();
    send_cmd(2'd2, 7'd7);
    send_beats(2'd2, 7, 0, 1'b1);
    wait_drain();
    fill_random();
    send_cmd(2'd3, 7'd9);
    send_beats(2'd3, 9, 0, 1'b1);
    wait_drain();
    rnd_rdy = 1'b0;
    tick();

    // VL=0 command: accepted, no output.
    p0 = popped;
    send_cmd(2'd0, 7'd0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("vl0_idle", {cmd_ready, out_valid}, {1'b1, 1'b0});
    end
    tick();

    // Command presented while RUN is held off.
    fill_random();
    send_cmd(2'd1, 7'd4);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_vl    = 7'd8;
    @(negedge clk);
    check("cmd_ready_in_run", {31'h0, cmd_ready}, 32'h0);
    tick();
    send_beats(2'd1, 4, 0, 1'b0);
    cmd_valid = 1'b0;
    wait_drain();
    check("run_cmd_ignored", 64'(popped - p0), 64'd1);

    // Async reset after 2 of 4 beats.
    fill_random();
    send_cmd(2'd0, 7'd16);
    send_beats(2'd0, 16, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midvec_reset",
          {cmd_ready, in_ready, out_valid, out_last, out_flag, out_mask, out_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0});
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      va[i] = 8'(i + 1);
      vb[i] = 8'((i + 1) * 10);
    end
    p0 = popped;
    send_cmd(2'd0, 7'd4);
    send_beats(2'd0, 4, 0, 1'b0);
    wait_drain();
    check("post_reset_beats", 64'(popped - p0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
